// File: rtl/ysyx_22050612_wb_arbiter.sv
// Writeback arbiter: the ALU and LSU share one registered GPR write stage, which also supplies operand forwarding.
// Optional macro WB_ARB_AGE_EN: once the ALU has been starved for MAX_WAIT cycles, it is promoted over the LSU.
module ysyx_22050612_wb_arbiter #(
    parameter int DW       = 64,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_wdata,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_rd,
    input  logic [DW-1:0] lsu_wdata,
    input  logic          wb_stall,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] fwd_rs,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic          s_valid_reg;
    logic [AW-1:0] s_rd_reg;
    logic [DW-1:0] s_data_reg;
    logic [WW-1:0] wait_cnt_reg;

    logic          load_ok;
    logic          alu_first;
    logic          alu_xfer;
    logic          lsu_xfer;
    logic          xfer;
    logic [AW-1:0] win_rd;
    logic [DW-1:0] win_data;

    // The stage can accept a new result when it is empty or when it drains this cycle.
    assign load_ok   = ~s_valid_reg | ~wb_stall;
    assign alu_first = (wait_cnt_reg == WW'(MAX_WAIT));

    // The ready signals look only at the other requester's valid, never at the requester's own valid.
    assign lsu_ready = ~rst & load_ok & (alu_first ? ~alu_valid : 1'b1);
    assign alu_ready = ~rst & load_ok & (alu_first ? 1'b1 : ~lsu_valid);

    assign alu_xfer  = alu_valid & alu_ready;
    assign lsu_xfer  = lsu_valid & lsu_ready;
    assign xfer      = alu_xfer | lsu_xfer;
    assign win_rd    = lsu_xfer ? lsu_rd : alu_rd;
    assign win_data  = lsu_xfer ? lsu_wdata : alu_wdata;

    assign wen      = s_valid_reg & ~wb_stall & ~rst;
    assign waddr    = s_rd_reg;
    assign wdata    = s_data_reg;
    assign fwd_hit  = s_valid_reg & (s_rd_reg == fwd_rs) & (fwd_rs != '0);
    assign fwd_data = fwd_hit ? s_data_reg : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_reg <= 1'b0;
            s_rd_reg    <= '0;
            s_data_reg  <= '0;
        end else if (xfer) begin
            // A write to x0 completes its handshake but leaves the stage empty.
            s_valid_reg <= (win_rd != '0);
            if (win_rd != '0) begin
                s_rd_reg   <= win_rd;
                s_data_reg <= win_data;
            end
        end else if (load_ok) begin
            s_valid_reg <= 1'b0;
        end
    end

`ifdef WB_ARB_AGE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (~alu_valid || alu_xfer) begin
            wait_cnt_reg <= '0;
        end else if (load_ok && wait_cnt_reg != WW'(MAX_WAIT)) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end
`else
    assign wait_cnt_reg = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050612_wb_arbiter.sv
// Directed testbench for ysyx_22050612_wb_arbiter. It covers reset, the single write, arbitration, stall, x0 writes, back-to-back writes, priority and reset of a full stage.
module tb_ysyx_22050612_wb_arbiter;
    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [AW-1:0] alu_rd, lsu_rd, waddr, fwd_rs;
    logic [DW-1:0] alu_wdata, lsu_wdata, wdata, fwd_data;
    logic          wb_stall, wen, fwd_hit;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_22050612_wb_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
        .wb_stall(wb_stall), .wen(wen), .waddr(waddr), .wdata(wdata),
        .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_valid = 0; lsu_valid = 0; wb_stall = 0;
        alu_rd = 0; lsu_rd = 0; alu_wdata = 0; lsu_wdata = 0; fwd_rs = 0;
        tick(); tick();
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL rst_wen got %b exp 0", wen); end
        tests++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b%b exp 00", alu_ready, lsu_ready); end
        rst = 1'b0; #1;
        tests++; if (wen !== 1'b0 || waddr !== '0 || wdata !== '0) begin fails++; $display("FAIL idle_out got %b %h %h exp 0 0 0", wen, waddr, wdata); end
        tests++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin fails++; $display("FAIL idle_ready got %b%b exp 11", alu_ready, lsu_ready); end
        tests++; if (fwd_hit !== 1'b0) begin fails++; $display("FAIL idle_fwd got %b exp 0", fwd_hit); end
        $display("[TB] reset done");
    endtask

    task automatic test_alu_single();
        alu_valid = 1; alu_rd = 5; alu_wdata = 64'h10; #1;
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL alu_ready got %b exp 1", alu_ready); end
        tick();
        alu_valid = 0; fwd_rs = 5; #1;
        tests++; if (wen !== 1'b1 || waddr !== 5'd5 || wdata !== 64'h10) begin fails++; $display("FAIL alu_write got %b %0d %h exp 1 5 10", wen, waddr, wdata); end
        tests++; if (fwd_hit !== 1'b1 || fwd_data !== 64'h10) begin fails++; $display("FAIL alu_fwd got %b %h exp 1 10", fwd_hit, fwd_data); end
        tick();
        tests++; if (wen !== 1'b0 || fwd_hit !== 1'b0) begin fails++; $display("FAIL alu_drain got %b %b exp 0 0", wen, fwd_hit); end
        $display("[TB] alu write rd=5 data=10");
    endtask

    task automatic test_both_valid();
        lsu_valid = 1; lsu_rd = 3; lsu_wdata = 64'hAA;
        alu_valid = 1; alu_rd = 4; alu_wdata = 64'hBB; #1;
        tests++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin fails++; $display("FAIL both_grant got lsu=%b alu=%b exp 1 0", lsu_ready, alu_ready); end
        tick();
        lsu_valid = 0; #1;
        tests++; if (wen !== 1'b1 || waddr !== 5'd3 || wdata !== 64'hAA) begin fails++; $display("FAIL both_lsu_write got %b %0d %h exp 1 3 aa", wen, waddr, wdata); end
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL both_alu_ready got %b exp 1", alu_ready); end
        tick();
        alu_valid = 0; #1;
        tests++; if (wen !== 1'b1 || waddr !== 5'd4 || wdata !== 64'hBB) begin fails++; $display("FAIL both_alu_write got %b %0d %h exp 1 4 bb", wen, waddr, wdata); end
        tick();
        $display("[TB] lsu rd=3 then alu rd=4");
    endtask

    task automatic test_stall();
        alu_valid = 1; alu_rd = 7; alu_wdata = 64'h77;
        tick();
        alu_valid = 1; alu_rd = 9; alu_wdata = 64'h99;
        lsu_valid = 1; lsu_rd = 8; lsu_wdata = 64'h88;
        wb_stall = 1; fwd_rs = 7;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (wen !== 1'b0 || waddr !== 5'd7) begin fails++; $display("FAIL stall_hold%0d got %b %0d exp 0 7", i, wen, waddr); end
            tests++; if (lsu_ready !== 1'b0 || alu_ready !== 1'b0) begin fails++; $display("FAIL stall_ready%0d got %b%b exp 00", i, lsu_ready, alu_ready); end
            tests++; if (fwd_hit !== 1'b1 || fwd_data !== 64'h77) begin fails++; $display("FAIL stall_fwd%0d got %b %h exp 1 77", i, fwd_hit, fwd_data); end
            tick();
        end
        wb_stall = 0; #1;
        tests++; if (wen !== 1'b1 || waddr !== 5'd7 || wdata !== 64'h77) begin fails++; $display("FAIL unstall_write got %b %0d %h exp 1 7 77", wen, waddr, wdata); end
        tests++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL unstall_ready got %b exp 1", lsu_ready); end
        tick();
        lsu_valid = 0; #1;
        tests++; if (wen !== 1'b1 || waddr !== 5'd8 || wdata !== 64'h88) begin fails++; $display("FAIL unstall_lsu got %b %0d %h exp 1 8 88", wen, waddr, wdata); end
        tick();
        alu_valid = 0; #1;
        tests++; if (wen !== 1'b1 || waddr !== 5'd9 || wdata !== 64'h99) begin fails++; $display("FAIL unstall_alu got %b %0d %h exp 1 9 99", wen, waddr, wdata); end
        tick();
        $display("[TB] stall rd=7 x3, then rd=8, rd=9");
    endtask

    task automatic test_rd_zero();
        alu_valid = 1; alu_rd = 0; alu_wdata = 64'hFF; #1;
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL x0_ready got %b exp 1", alu_ready); end
        tick();
        alu_valid = 0; fwd_rs = 0; #1;
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL x0_wen got %b exp 0", wen); end
        tests++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin fails++; $display("FAIL x0_fwd got %b %h exp 0 0", fwd_hit, fwd_data); end
        tick();
        $display("[TB] alu rd=0 dropped");
    endtask

    task automatic test_back_to_back();
        alu_valid = 1; alu_rd = 6; alu_wdata = 64'h1;
        tick();
        alu_wdata = 64'h2; fwd_rs = 6; #1;
        tests++; if (wen !== 1'b1 || waddr !== 5'd6 || wdata !== 64'h1) begin fails++; $display("FAIL b2b_first got %b %0d %h exp 1 6 1", wen, waddr, wdata); end
        tick();
        alu_valid = 0; #1;
        tests++; if (wen !== 1'b1 || waddr !== 5'd6 || wdata !== 64'h2) begin fails++; $display("FAIL b2b_second got %b %0d %h exp 1 6 2", wen, waddr, wdata); end
        tests++; if (fwd_data !== 64'h2) begin fails++; $display("FAIL b2b_fwd got %h exp 2", fwd_data); end
        tick();
        $display("[TB] back-to-back rd=6 data 1,2");
    endtask

    task automatic test_priority();
        logic          exp_alu;
        logic [AW-1:0] exp_addr;
        logic          age;
`ifdef WB_ARB_AGE_EN
        age = 1'b1;
`else
        age = 1'b0;
`endif
        alu_valid = 1; alu_rd = 11; alu_wdata = 64'hB0;
        lsu_valid = 1; lsu_rd = 10; lsu_wdata = 64'hA0;
        for (int i = 1; i <= 6; i++) begin
            exp_alu = age && (i == 5);
            #1;
            tests++; if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin fails++; $display("FAIL prio_cyc%0d got alu=%b lsu=%b exp alu=%b", i, alu_ready, lsu_ready, exp_alu); end
            exp_addr = exp_alu ? 5'd11 : 5'd10;
            tick();
            tests++; if (wen !== 1'b1 || waddr !== exp_addr) begin fails++; $display("FAIL prio_write%0d got %b %0d exp 1 %0d", i, wen, waddr, exp_addr); end
        end
        lsu_valid = 0; #1;
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL prio_release got %b exp 1", alu_ready); end
        tick();
        alu_valid = 0; #1;
        tests++; if (waddr !== 5'd11 || wdata !== 64'hB0) begin fails++; $display("FAIL prio_alu_write got %0d %h exp 11 b0", waddr, wdata); end
        tick();
        $display("[TB] priority test age=%0b", age);
    endtask

    task automatic test_reset_full();
        alu_valid = 1; alu_rd = 12; alu_wdata = 64'hC0;
        tick();
        alu_valid = 0; wb_stall = 1; rst = 1; fwd_rs = 12; #1;
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL rstfull_wen got %b exp 0", wen); end
        tick();
        rst = 0; wb_stall = 0; #1;
        tests++; if (wen !== 1'b0 || waddr !== '0 || fwd_hit !== 1'b0) begin fails++; $display("FAIL rstfull_after got %b %0d %b exp 0 0 0", wen, waddr, fwd_hit); end
        $display("[TB] reset with full stage");
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_both_valid();
        test_stall();
        test_rd_zero();
        test_back_to_back();
        test_priority();
        test_reset_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
